// File: rtl/bill_acceptor_if.sv
// Bill-acceptor signal bundle: vend/sensor side is the master, the acceptor is the slave.
interface bill_acceptor_if #(
  parameter int CREDIT_W = 4
);
  logic                bill_raw;
  logic                cancel;
  logic                consume;
  logic [1:0]          consume_amt;
  logic                dollar;
  logic                reject;
  logic                consume_ok;
  logic                consume_err;
  logic                change_pulse;
  logic [CREDIT_W-1:0] credit;
  logic                busy;

  modport master (
    output bill_raw, cancel, consume, consume_amt,
    input  dollar, reject, consume_ok, consume_err, change_pulse, credit, busy
  );

  modport slave (
    input  bill_raw, cancel, consume, consume_amt,
    output dollar, reject, consume_ok, consume_err, change_pulse, credit, busy
  );
endinterface

// File: rtl/bill_acceptor.sv
// Payment front end: synchronises/debounces the bill sensor, keeps a saturating
// credit balance debited by the vend logic, and pays change back as a paced pulse train.
module bill_acceptor #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CREDIT_W        = 4,
  parameter int MAX_CREDIT      = 9,
  parameter int REFUND_GAP      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  bill_acceptor_if.slave   bus
);

  localparam logic [7:0]          DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [CREDIT_W-1:0] MAX_C   = CREDIT_W'(MAX_CREDIT);
  localparam int                  GAP_W   = (REFUND_GAP > 1) ? $clog2(REFUND_GAP) : 1;
  localparam logic [GAP_W-1:0]    GAP_LD  = GAP_W'(REFUND_GAP - 1);

  typedef enum logic [1:0] {DB_LOW, DB_RISE, DB_HIGH, DB_FALL} db_state_t;
  typedef enum logic [1:0] {IDLE, REFUND, GAP} main_state_t;

  logic                sync_p0, sync_p1;
  db_state_t           db_state;
  logic [7:0]          cnt;
  logic                s;
  logic                accept;

  main_state_t         state;
  logic [GAP_W-1:0]    gap_cnt;
  logic [CREDIT_W-1:0] credit;
  logic                dollar, reject, consume_ok, consume_err, change_pulse, busy;

  logic [CREDIT_W-1:0] amt_ext, debit, credit_idle;
  logic                can_pay, can_add;

  assign s = sync_p1;
  // The accept fires on the same edge the counter would reach DEBOUNCE_CYCLES.
  assign accept = (db_state == DB_RISE) && s && (cnt == DB_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0  <= 1'b0;
      sync_p1  <= 1'b0;
      db_state <= DB_LOW;
      cnt      <= 8'd0;
    end else begin
      sync_p0 <= bus.bill_raw;
      sync_p1 <= sync_p0;
      case (db_state)
        DB_LOW: if (s) begin
          db_state <= DB_RISE;
          cnt      <= 8'd1;
        end
        DB_RISE: begin
          if (!s) begin
            db_state <= DB_LOW;
            cnt      <= 8'd0;
          end else if (cnt == DB_LAST) begin
            db_state <= DB_HIGH;
            cnt      <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DB_HIGH: if (!s) begin
          db_state <= DB_FALL;
          cnt      <= 8'd1;
        end
        DB_FALL: begin
          if (s) begin
            db_state <= DB_HIGH;
            cnt      <= 8'd0;
          end else if (cnt == DB_LAST) begin
            db_state <= DB_LOW;
            cnt      <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          db_state <= DB_LOW;
          cnt      <= 8'd0;
        end
      endcase
    end
  end

  // Debit is judged against the pre-accept balance; the add is gated the same way, so no wrap.
  always_comb begin
    amt_ext     = CREDIT_W'(bus.consume_amt);
    can_pay     = (amt_ext <= credit);
    can_add     = (credit < MAX_C);
    debit       = (bus.consume && can_pay) ? amt_ext : '0;
    credit_idle = credit - debit + CREDIT_W'(accept && can_add);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      gap_cnt      <= '0;
      credit       <= '0;
      dollar       <= 1'b0;
      reject       <= 1'b0;
      consume_ok   <= 1'b0;
      consume_err  <= 1'b0;
      change_pulse <= 1'b0;
      busy         <= 1'b0;
    end else begin
      dollar       <= 1'b0;
      reject       <= 1'b0;
      consume_ok   <= 1'b0;
      consume_err  <= 1'b0;
      change_pulse <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (bus.cancel && credit != '0) begin
            state       <= REFUND;
            reject      <= accept;
            consume_err <= bus.consume;
          end else begin
            dollar      <= accept && can_add;
            reject      <= accept && !can_add;
            consume_ok  <= bus.consume && can_pay;
            consume_err <= bus.consume && !can_pay;
            credit      <= credit_idle;
          end
        end
        REFUND: begin
          busy         <= 1'b1;
          reject       <= accept;
          consume_err  <= bus.consume;
          change_pulse <= 1'b1;
          credit       <= credit - CREDIT_W'(1);
          if (credit == CREDIT_W'(1)) begin
            state <= IDLE;
          end else begin
            state   <= GAP;
            gap_cnt <= GAP_LD;
          end
        end
        GAP: begin
          busy        <= 1'b1;
          reject      <= accept;
          consume_err <= bus.consume;
          if (gap_cnt == '0) state <= REFUND;
          else               gap_cnt <= gap_cnt - GAP_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dollar       = dollar;
  assign bus.reject       = reject;
  assign bus.consume_ok   = consume_ok;
  assign bus.consume_err  = consume_err;
  assign bus.change_pulse = change_pulse;
  assign bus.credit       = credit;
  assign bus.busy         = busy;

endmodule

// File: tb/tb_bill_acceptor.sv
// Bench for bill_acceptor: directed scenarios plus random traffic, every cycle
// compared against a behavioural model of sensor delay, run-length debounce and credit rules.
module tb_bill_acceptor;

  localparam int DB   = 4;
  localparam int GAPP = 8;
  localparam int MAXC = 9;
  localparam int CW   = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bill_acceptor_if #(.CREDIT_W(CW)) bus ();

  bill_acceptor #(
    .DEBOUNCE_CYCLES(DB),
    .CREDIT_W(CW),
    .MAX_CREDIT(MAXC),
    .REFUND_GAP(GAPP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  bit m_s1, m_s2, m_lvl;
  int m_run, m_credit, m_wait;
  bit m_ref;
  bit e_dollar, e_reject, e_ok, e_err, e_change, e_busy;
  int pulse_count;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit acc, s;
    {e_dollar, e_reject, e_ok, e_err, e_change, e_busy} = '0;
    if (!rst_n) begin
      m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0;
      m_credit = 0; m_ref = 0; m_wait = 0;
      return;
    end
    acc = 0;
    s   = m_s2;
    if (s != m_lvl) begin
      m_run++;
      if (m_run == DB) begin
        m_lvl = s;
        m_run = 0;
        acc   = s;
      end
    end else begin
      m_run = 0;
    end
    m_s2 = m_s1;
    m_s1 = bus.bill_raw;

    e_busy = m_ref;
    if (m_ref) begin
      e_reject = acc;
      e_err    = bus.consume;
      if (m_wait == 0) begin
        e_change = 1;
        m_credit--;
        if (m_credit == 0) m_ref = 0;
        else               m_wait = GAPP;
      end else begin
        m_wait--;
      end
    end else if (bus.cancel && m_credit > 0) begin
      m_ref    = 1;
      m_wait   = 0;
      e_reject = acc;
      e_err    = bus.consume;
    end else begin
      if (bus.consume) begin
        if (int'(bus.consume_amt) <= m_credit) e_ok = 1;
        else                                   e_err = 1;
      end
      if (acc) begin
        if (m_credit < MAXC) e_dollar = 1;
        else                 e_reject = 1;
      end
      m_credit = m_credit - (e_ok ? int'(bus.consume_amt) : 0) + (e_dollar ? 1 : 0);
    end
  endtask

  task automatic step(input logic raw, input logic cn, input logic cs,
                      input logic [1:0] amt, input logic rn);
    bus.bill_raw    = raw;
    bus.cancel      = cn;
    bus.consume     = cs;
    bus.consume_amt = amt;
    rst_n           = rn;
    @(posedge clk);
    model_edge();
    #1;
    check("dollar",       32'(bus.dollar),       32'(e_dollar));
    check("reject",       32'(bus.reject),       32'(e_reject));
    check("consume_ok",   32'(bus.consume_ok),   32'(e_ok));
    check("consume_err",  32'(bus.consume_err),  32'(e_err));
    check("change_pulse", 32'(bus.change_pulse), 32'(e_change));
    check("busy",         32'(bus.busy),         32'(e_busy));
    check("credit",       32'(bus.credit),       32'(m_credit));
    if (bus.change_pulse === 1'b1) pulse_count++;
    @(negedge clk);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
  endtask

  task automatic bill();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
    idle_n(8);
  endtask

  task automatic consume(input logic [1:0] amt);
    step(1'b0, 1'b0, 1'b1, amt, 1'b1);
  endtask

  initial begin
    int hold;
    logic raw, cn, cs, rn;
    logic [1:0] amt;

    // reset
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    check("reset_credit", 32'(bus.credit), 32'd0);
    check("reset_busy",   32'(bus.busy),   32'd0);
    idle_n(4);

    // clean bill: dollar exactly in the cycle after edge E0+DB+1
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
      if (i == DB + 1) check("dollar_latency", 32'(bus.dollar), 32'd1);
      if (i == DB)     check("dollar_early",   32'(bus.dollar), 32'd0);
    end
    idle_n(8);
    check("credit_after_bill", 32'(bus.credit), 32'd1);

    // 3-cycle glitch: rejected by the debouncer
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
    idle_n(8);
    check("credit_after_glitch", 32'(bus.credit), 32'd1);

    // bouncing insertion then steady
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    bill();
    check("credit_after_bounce", 32'(bus.credit), 32'd2);

    consume(2'd1);
    check("consume_ok_1", 32'(bus.consume_ok), 32'd1);
    consume(2'd3);
    check("consume_err_3", 32'(bus.consume_err), 32'd1);
    check("credit_after_err", 32'(bus.credit), 32'd1);

    // fill to the ceiling then overflow
    for (int i = 0; i < 8; i++) bill();
    check("credit_full", 32'(bus.credit), 32'd9);
    bill();
    check("credit_sat", 32'(bus.credit), 32'd9);
    consume(2'd2);
    check("credit_7", 32'(bus.credit), 32'd7);
    consume(2'd3);
    consume(2'd2);
    check("credit_2", 32'(bus.credit), 32'd2);

    // accept and consume on the same edge
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b0, (i == DB + 1), 2'd2, 1'b1);
    idle_n(8);
    check("credit_same_cycle", 32'(bus.credit), 32'd1);

    // refund of 3 with a consume mid-refund
    bill();
    bill();
    check("credit_3", 32'(bus.credit), 32'd3);
    pulse_count = 0;
    step(1'b0, 1'b1, 1'b0, 2'd0, 1'b1);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, (i == 5), 2'd1, 1'b1);
    check("refund_pulses", 32'(pulse_count), 32'd3);
    check("credit_refunded", 32'(bus.credit), 32'd0);

    // reset during a gap
    bill();
    bill();
    step(1'b0, 1'b1, 1'b0, 2'd0, 1'b1);
    idle_n(4);
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    pulse_count = 0;
    idle_n(20);
    check("abort_pulses", 32'(pulse_count), 32'd0);
    check("abort_credit", 32'(bus.credit), 32'd0);
    check("abort_busy",   32'(bus.busy),   32'd0);

    // random traffic
    hold = 0;
    raw  = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        raw  = ~raw;
        hold = $urandom_range(1, 12);
      end
      hold--;
      cn  = ($urandom_range(0, 59) == 0);
      cs  = ($urandom_range(0, 7) == 0);
      amt = 2'($urandom_range(0, 3));
      rn  = ($urandom_range(0, 699) != 0);
      step(raw, cn, cs, amt, rn);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bill_acceptor.md
# bill_acceptor

- Front-end payment stage of the juice vending path.
- Synchronises and debounces the mechanical bill-sensor line, then turns each accepted bill into a one-cycle `dollar` pulse for the downstream juice state machine.
- Keeps a saturating credit balance that the vend logic debits through a request/response interface.
- Pays back outstanding credit as a paced train of `change_pulse` outputs on cancel.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 16. Consecutive synchronised-stable cycles required to accept a level change (legal range 2..255).
- `CREDIT_W`, default 4. Width of the credit counter.
- `MAX_CREDIT`, default 9. Credit ceiling; must be < 2^CREDIT_W.
- `REFUND_GAP`, default 8. Cycles between successive change pulses (≥1).

Ports:
- `clk` in 1: single clock; every register is rising-edge.
- `rst_n` in 1: reset, synchronous, active-low. One clock; reset is synchronous and active-low.
- `bill_raw` in 1: asynchronous, bouncy bill sensor; high while a bill is present.
- `cancel` in 1: refund request, sampled per cycle.
- `consume` in 1: single-cycle debit request from vend logic.
- `consume_amt` in 2: amount to debit, valid when `consume`=1. 0 is legal.
- `dollar` out 1: one-cycle pulse per accepted bill.
- `reject` out 1: one-cycle pulse when a debounced bill cannot be credited.
- `consume_ok` out 1: one-cycle debit success.
- `consume_err` out 1: one-cycle debit failure.
- `change_pulse` out 1: one-cycle pulse, one per refunded dollar.
- `credit` out CREDIT_W: current balance.
- `busy` out 1: high while refunding.

## Operation

- Synchroniser: two flops on `bill_raw`; the second-flop output `s` is the only value the debouncer uses.
- Debouncer FSM:
  - States: DB_LOW, DB_RISE, DB_HIGH, DB_FALL. 8-bit counter `cnt`.
  - DB_LOW → DB_RISE when s=1, with cnt=1.
  - In DB_RISE, s=1 increments cnt. When cnt reaches DEBOUNCE_CYCLES, go to DB_HIGH and emit an `accept` event. s=0 returns to DB_LOW with cnt=0.
  - DB_HIGH → DB_FALL when s=0, with cnt=1.
  - In DB_FALL, s=0 increments cnt. When cnt reaches DEBOUNCE_CYCLES, go to DB_LOW. s=1 returns to DB_HIGH.
  - Result: exactly one `accept` per debounced high period. A bill must be debounced low before the next one can be accepted.
- Main FSM: IDLE, REFUND, GAP.
- IDLE:
  - `accept` with credit < MAX_CREDIT: credit += 1 and `dollar` pulses.
  - `accept` with credit == MAX_CREDIT: `reject` pulses, credit unchanged, no `dollar`.
  - `consume`: if consume_amt ≤ credit (the pre-accept value of the same cycle), credit -= consume_amt and `consume_ok` pulses; otherwise `consume_err` pulses and credit is unchanged.
  - `accept` and a successful `consume` in the same cycle: credit_next = credit − amt + 1. The add is gated on the pre-accept credit < MAX_CREDIT, so no wrap.
  - `cancel` with credit > 0: go to REFUND; it takes priority over `consume` in the same cycle, which returns `consume_err`. A same-cycle `accept` is rejected.
  - `cancel` with credit == 0: no effect.
- REFUND:
  - `change_pulse`=1 and credit −= 1.
  - If the new credit is 0, go to IDLE; otherwise go to GAP and load the gap counter with REFUND_GAP−1.
- GAP:
  - Counts down; at 0, go to REFUND.
  - If REFUND_GAP = 1, GAP lasts 1 cycle, giving pulse spacing 2.
- REFUND and GAP (`busy`=1):
  - Every `accept` produces `reject`.
  - Every `consume` produces `consume_err`.
  - `cancel` is ignored.
- Reset: all state cleared, debouncer in DB_LOW, main FSM in IDLE, synchroniser flops 0.

## Timing

- Reset values: `dollar`, `reject`, `consume_ok`, `consume_err`, `change_pulse`, `busy` = 0; `credit` = 0.
- All outputs are registered.
- Accept latency: `bill_raw` first sampled high at edge E0 and held steady gives `dollar` high in the single cycle after edge E0+DEBOUNCE_CYCLES+1. `credit` updates on that same edge.
- Consume response: `consume_ok`/`consume_err` and the updated `credit` appear one cycle after the request edge. Exactly one of the two pulses per request.
- Refund: first `change_pulse` one cycle after the `cancel` edge. Successive pulses are REFUND_GAP+1 cycles apart. `busy` rises with the first pulse and falls the cycle after the last.
- Mid-operation `rst_n`=0: effective at the next edge. Credit is lost, refund is aborted, no further pulses.

## Test plan

- DEBOUNCE_CYCLES=4, clean `bill_raw` high for 10 cycles → one `dollar` at edge E0+5, credit 0→1; glitch of 3 cycles → no `dollar`.
- Bouncing `bill_raw` (1,0,1,0 then steady 1) → exactly one `dollar`; second bill only after ≥4 stable low cycles.
- credit=9, accept → `reject`, credit stays 9; consume amt=2 → `consume_ok`, credit 7; consume amt=3 at credit 1 → `consume_err`, credit 1.
- credit=3, REFUND_GAP=8, `cancel` → 3 `change_pulse` spaced 9 cycles, credit 3→0, `busy` high throughout; a consume mid-refund → `consume_err`.
- Same-cycle accept + consume amt=2 at credit 2 → `dollar` + `consume_ok`, credit 1.
- `rst_n` low during GAP with credit 2 → credit 0, no further `change_pulse`, `busy`=0.
